// File: rtl/nand_flash_responder.sv
// NAND flash device model for the controller's CLE/ALE/wEn/rEn/cEn/DIO bus.
// Handles erase, program (AND into the array) and page read, and pulses status when each operation finishes.
module nand_flash_responder #(
    parameter int DIOWidth      = 16,
    parameter int PageSize      = 2048,
    parameter int NumPages      = 4,
    parameter int PagesPerBlock = 2,
    parameter int ProgLatency   = 8,
    parameter int ReadLatency   = 2
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                cEn,
    input  logic                CLE,
    input  logic                ALE,
    input  logic                wEn,
    input  logic                rEn,
    inout  wire [DIOWidth-1:0]  DIO,
    output logic                status,
    output logic                busy,
    output logic                cmd_err
);

    localparam int PW          = (NumPages > 1) ? $clog2(NumPages) : 1;
    localparam int WW          = $clog2(PageSize);
    localparam int BW          = $clog2(PagesPerBlock);
    localparam int CW          = WW + BW;
    localparam int AW          = PW + WW;
    localparam int DEPTH       = 1 << AW;
    localparam int BLOCK_WORDS = PagesPerBlock * PageSize;
    localparam int MAX_LAT     = (ProgLatency > ReadLatency) ? ProgLatency : ReadLatency;
    localparam int TW          = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_PROG_BUSY, S_RWAIT, S_RDATA, S_ERASE, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_ERASE = 2'd0,
        CMD_PROG  = 2'd1,
        CMD_READ  = 2'd2
    } cmd_t;

    state_t                state_reg;
    cmd_t                  cmd_reg;
    logic [PW-1:0]         page_reg;
    logic [CW-1:0]         word_cnt_reg;
    logic [TW-1:0]         timer_reg;
    logic [DIOWidth-1:0]   dout_reg;
    logic [DIOWidth-1:0]   mem [DEPTH];

    logic [AW-1:0]         page_base;
    logic [AW-1:0]         erase_addr;
    logic [AW-1:0]         prog_addr;
    logic [AW-1:0]         rd_addr;
    logic [WW-1:0]         next_word;
    logic                  prog_we;
    logic                  erase_we;
    logic                  rd_en;
    logic                  drive_dio;

    // Erase walks the whole block starting at its first page, whatever page was addressed.
    assign page_base  = {page_reg, {WW{1'b0}}};
    assign erase_addr = (page_base & ~AW'(BLOCK_WORDS - 1)) | AW'(word_cnt_reg);
    assign prog_addr  = page_base | AW'(word_cnt_reg[WW-1:0]);
    assign next_word  = word_cnt_reg[WW-1:0] + WW'(1);
    assign rd_addr    = (state_reg == S_RDATA) ? (page_base | AW'(next_word)) : page_base;

    assign prog_we   = (state_reg == S_WDATA) && cEn && wEn;
    assign erase_we  = (state_reg == S_ERASE);
    assign rd_en     = (state_reg == S_RWAIT) || ((state_reg == S_RDATA) && cEn && rEn);
    assign drive_dio = (state_reg == S_RDATA) && cEn && rEn;

    assign DIO = drive_dio ? dout_reg : 'z;

    // Array has no reset: contents survive reset, like real flash.
    always_ff @(posedge clk) begin
        if (erase_we) begin
            mem[erase_addr] <= '1;
        end else if (prog_we) begin
            mem[prog_addr] <= mem[prog_addr] & DIO;
        end
        if (rd_en) begin
            dout_reg <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            cmd_reg      <= CMD_ERASE;
            page_reg     <= '0;
            word_cnt_reg <= '0;
            timer_reg    <= '0;
            status       <= 1'b0;
            busy         <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            status  <= 1'b0;
            cmd_err <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cEn && CLE) begin
                        if (ALE) begin
                            cmd_err <= 1'b1;
                        end else if (DIO == DIOWidth'(0)) begin
                            cmd_reg   <= CMD_ERASE;
                            state_reg <= S_ADDR;
                        end else if (DIO == DIOWidth'(1)) begin
                            cmd_reg   <= CMD_PROG;
                            state_reg <= S_ADDR;
                        end else if (DIO == DIOWidth'(2)) begin
                            cmd_reg   <= CMD_READ;
                            state_reg <= S_ADDR;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (!cEn) begin
                        state_reg    <= S_IDLE;
                        word_cnt_reg <= '0;
                    end else if (ALE) begin
                        page_reg     <= DIO[PW-1:0];
                        word_cnt_reg <= '0;
                        case (cmd_reg)
                            CMD_ERASE: begin
                                state_reg <= S_ERASE;
                                busy      <= 1'b1;
                            end
                            CMD_PROG: begin
                                state_reg <= S_WDATA;
                            end
                            default: begin
                                state_reg <= S_RWAIT;
                                timer_reg <= TW'(ReadLatency);
                                busy      <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WDATA: begin
                    if (!cEn) begin
                        state_reg    <= S_IDLE;
                        word_cnt_reg <= '0;
                    end else if (wEn) begin
                        if (word_cnt_reg == CW'(PageSize - 1)) begin
                            word_cnt_reg <= '0;
                            state_reg    <= S_PROG_BUSY;
                            timer_reg    <= TW'(ProgLatency);
                            busy         <= 1'b1;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + CW'(1);
                        end
                    end
                end
                S_PROG_BUSY: begin
                    if (timer_reg <= TW'(1)) begin
                        timer_reg <= '0;
                        state_reg <= S_DONE;
                        busy      <= 1'b0;
                        status    <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                S_RWAIT: begin
                    if (!cEn) begin
                        state_reg    <= S_IDLE;
                        word_cnt_reg <= '0;
                        busy         <= 1'b0;
                    end else if (timer_reg <= TW'(1)) begin
                        timer_reg    <= '0;
                        word_cnt_reg <= '0;
                        state_reg    <= S_RDATA;
                        busy         <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                S_RDATA: begin
                    if (!cEn) begin
                        state_reg    <= S_IDLE;
                        word_cnt_reg <= '0;
                    end else if (rEn) begin
                        if (word_cnt_reg == CW'(PageSize - 1)) begin
                            word_cnt_reg <= '0;
                            state_reg    <= S_DONE;
                            status       <= 1'b1;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + CW'(1);
                        end
                    end
                end
                S_ERASE: begin
                    if (word_cnt_reg == CW'(BLOCK_WORDS - 1)) begin
                        word_cnt_reg <= '0;
                        state_reg    <= S_DONE;
                        busy         <= 1'b0;
                        status       <= 1'b1;
                    end else begin
                        word_cnt_reg <= word_cnt_reg + CW'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed bench for nand_flash_responder with a small geometry: 4 pages of 8 words, 2 pages per block.
// Command-decode vectors come from a table; erase/program/read/abort/reset use hand-written sequences.
module tb_nand_flash_responder;

    localparam int W   = 16;
    localparam int PS  = 8;
    localparam int NP  = 4;
    localparam int PPB = 2;
    localparam int PL  = 3;
    localparam int RL  = 2;

    logic         clk = 1'b0;
    logic         Reset;
    logic         cEn, CLE, ALE, wEn, rEn;
    logic         tb_oe;
    logic [W-1:0] tb_dio;
    wire  [W-1:0] DIO;
    logic         status, busy, cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] wr_words  [PS];
    logic [W-1:0] exp_words [PS];

    typedef struct packed {
        logic         cen;
        logic         cle;
        logic         ale;
        logic [W-1:0] dio;
        logic         exp_err;
    } ivec_t;

    ivec_t ivec [5];

    assign DIO = tb_oe ? tb_dio : 'z;

    always #5 clk = ~clk;

    nand_flash_responder #(
        .DIOWidth(W), .PageSize(PS), .NumPages(NP), .PagesPerBlock(PPB),
        .ProgLatency(PL), .ReadLatency(RL)
    ) dut (
        .clk(clk), .Reset(Reset), .cEn(cEn), .CLE(CLE), .ALE(ALE),
        .wEn(wEn), .rEn(rEn), .DIO(DIO),
        .status(status), .busy(busy), .cmd_err(cmd_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        cEn = 1'b0; CLE = 1'b0; ALE = 1'b0; wEn = 1'b0; rEn = 1'b0;
        tb_oe = 1'b0; tb_dio = '0;
    endtask

    // Leaves the caller at the negedge after the address edge, cEn still high.
    task automatic cmd_addr(input logic [W-1:0] c, input logic [W-1:0] a);
        @(negedge clk);
        cEn = 1'b1; CLE = 1'b1; ALE = 1'b0; tb_oe = 1'b1; tb_dio = c;
        @(negedge clk);
        CLE = 1'b0; ALE = 1'b1; tb_dio = a;
        @(negedge clk);
        ALE = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic erase_page(input logic [W-1:0] pg);
        int nb;
        int ns;
        cmd_addr(16'h0, pg);
        cEn = 1'b0;
        nb = 0;
        ns = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy) nb++;
            if (status) ns++;
            @(negedge clk);
        end
        check($sformatf("erase p%0d busy cycles", pg), nb, PPB * PS);
        check($sformatf("erase p%0d status pulses", pg), ns, 1);
        $display("erase page %0d: busy %0d cycles, %0d status pulse(s)", pg, nb, ns);
    endtask

    task automatic prog_page(input logic [W-1:0] pg, input int nwords);
        int lat;
        cmd_addr(16'h1, pg);
        for (int i = 0; i < nwords; i++) begin
            tb_oe = 1'b1; wEn = 1'b1; tb_dio = wr_words[i];
            @(negedge clk);
        end
        wEn = 1'b0; tb_oe = 1'b0;
        if (nwords < PS) begin
            cEn = 1'b0;
            lat = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (status || busy) lat++;
            end
            check($sformatf("prog p%0d abort quiet", pg), lat, 0);
            $display("program page %0d: aborted after %0d words", pg, nwords);
        end else begin
            check($sformatf("prog p%0d busy after last word", pg), busy, 1'b1);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!status && lat < 20);
            check($sformatf("prog p%0d status latency", pg), lat, PL);
            check($sformatf("prog p%0d busy at status", pg), busy, 1'b0);
            @(negedge clk);
            check($sformatf("prog p%0d status drop", pg), status, 1'b0);
            cEn = 1'b0;
            $display("program page %0d: status %0d cycles after last word", pg, lat);
        end
    endtask

    task automatic read_page(input logic [W-1:0] pg, input string tag);
        int lat;
        cmd_addr(16'h2, pg);
        rEn = 1'b1;
        lat = 0;
        while (busy && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check($sformatf("%s read latency", tag), lat, RL);
        for (int i = 0; i < PS; i++) begin
            check($sformatf("%s word %0d", tag, i), DIO, exp_words[i]);
            @(negedge clk);
        end
        check($sformatf("%s status pulse", tag), status, 1'b1);
        rEn = 1'b0; cEn = 1'b0;
        @(negedge clk);
        check($sformatf("%s status drop", tag), status, 1'b0);
        $display("read page %0d (%s): first word 0x%04h", pg, tag, exp_words[0]);
    endtask

    initial begin
        ivec[0] = '{cen: 1'b1, cle: 1'b1, ale: 1'b0, dio: 16'h0007, exp_err: 1'b1};
        ivec[1] = '{cen: 1'b1, cle: 1'b1, ale: 1'b1, dio: 16'h0002, exp_err: 1'b1};
        ivec[2] = '{cen: 1'b1, cle: 1'b1, ale: 1'b0, dio: 16'hFFFF, exp_err: 1'b1};
        ivec[3] = '{cen: 1'b0, cle: 1'b1, ale: 1'b0, dio: 16'h0007, exp_err: 1'b0};
        ivec[4] = '{cen: 1'b1, cle: 1'b0, ale: 1'b1, dio: 16'h0001, exp_err: 1'b0};

        bus_idle();
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset status", status, 1'b0);
        check("reset cmd_err", cmd_err, 1'b0);
        Reset = 1'b0;
        @(negedge clk);
        check("post-reset busy", busy, 1'b0);

        // Erase block 0 via page 1, then both its pages read back erased.
        erase_page(16'h1);
        for (int i = 0; i < PS; i++) exp_words[i] = 16'hFFFF;
        read_page(16'h0, "erased p0");
        read_page(16'h1, "erased p1");

        // Block 1 holds undefined contents until erased.
        erase_page(16'h2);
        for (int i = 0; i < PS; i++) wr_words[i] = W'(i + 1);
        prog_page(16'h2, PS);
        for (int i = 0; i < PS; i++) exp_words[i] = W'(i + 1);
        read_page(16'h2, "prog p2");

        // Reprogramming can only clear bits: 000n & FF0F = 000n.
        for (int i = 0; i < PS; i++) wr_words[i] = 16'hFF0F;
        prog_page(16'h2, PS);
        read_page(16'h2, "reprog p2");

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            cEn = ivec[v].cen; CLE = ivec[v].cle; ALE = ivec[v].ale;
            tb_oe = 1'b1; tb_dio = ivec[v].dio;
            @(negedge clk);
            check($sformatf("idle vec %0d cmd_err", v), cmd_err, ivec[v].exp_err);
            check($sformatf("idle vec %0d busy", v), busy, 1'b0);
            check($sformatf("idle vec %0d status", v), status, 1'b0);
            bus_idle();
            @(negedge clk);
            check($sformatf("idle vec %0d cmd_err drop", v), cmd_err, 1'b0);
            $display("idle vector %0d: cle=%0b ale=%0b dio=0x%04h cmd_err=%0b",
                     v, ivec[v].cle, ivec[v].ale, ivec[v].dio, ivec[v].exp_err);
        end
        read_page(16'h2, "after errors");

        // Abort a program after three words.
        wr_words[0] = 16'h1234;
        wr_words[1] = 16'hA5A5;
        wr_words[2] = 16'h00F0;
        prog_page(16'h0, 3);
        exp_words[0] = 16'h1234;
        exp_words[1] = 16'hA5A5;
        exp_words[2] = 16'h00F0;
        for (int i = 3; i < PS; i++) exp_words[i] = 16'hFFFF;
        read_page(16'h0, "aborted p0");

        // Reset while erase of block 1 (via page 3) is about to write word 5.
        cmd_addr(16'h0, 16'h3);
        cEn = 1'b0;
        repeat (5) @(negedge clk);
        Reset = 1'b1;
        #1;
        check("mid-erase reset busy", busy, 1'b0);
        check("mid-erase reset status", status, 1'b0);
        @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        check("after reset busy", busy, 1'b0);
        $display("reset asserted during erase of block 1 at word 5");
        for (int i = 0; i < 5; i++) exp_words[i] = 16'hFFFF;
        exp_words[5] = 16'h0006;
        exp_words[6] = 16'h0007;
        exp_words[7] = 16'h0008;
        read_page(16'h2, "partial erase p2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
